fifo_rd_packer: RTL and testbench

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

---
 rtl/fifo_pkg.sv | 6 +
 rtl/fifo_rd_packer.sv | 61 ++++++
 tb/tb_fifo_rd_packer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared packer state type and default sizing
package fifo_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int PACK_DEF = 4;
  typedef enum logic {FILL, HOLD} state_t;
endpackage

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: packs PACK fifo read entries into one wide output word, with flush of partial words
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PACK = PACK_DEF
) (
  input  logic                       rclk,
  input  logic                       rrst,
  input  logic                       empty,
  input  logic [DATA_WIDTH-1:0]      fifo_data,
  output logic                       r_en,
  input  logic                       flush,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [PACK*DATA_WIDTH-1:0] m_data,
  output logic [PACK-1:0]            m_keep,
  output logic [15:0]                word_cnt
);
  localparam int CW = $clog2(PACK + 1);
  state_t state, state_nx;
  logic [CW-1:0] byte_cnt;
  logic inflight, flush_pend, flush_go, last, fill_done;
  logic [DATA_WIDTH-1:0] lanes [PACK];
  always_comb begin
    m_data = '0;
    m_keep = '0;
    last = inflight && (byte_cnt == CW'(PACK - 1));
    flush_go = flush_pend && !inflight && (byte_cnt != '0);
    state_nx = (state == HOLD) ? (m_ready ? FILL : HOLD) : ((last || flush_go) ? HOLD : FILL);
    fill_done = (state == FILL) && ((state_nx == HOLD) || ((byte_cnt == '0) && !inflight));
    r_en = !rrst && (state == FILL) && !flush_pend && !empty && ((int'(byte_cnt) + int'(inflight)) < PACK);
    m_valid = (state == HOLD);
    for (int i = 0; i < PACK; i++) begin
      m_data[i*DATA_WIDTH +: DATA_WIDTH] = m_valid ? lanes[i] : '0;
      m_keep[i] = m_valid && (CW'(i) < byte_cnt);
    end
  end
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state <= FILL;
      byte_cnt <= '0;
      inflight <= 1'b0;
      flush_pend <= 1'b0;
      word_cnt <= '0;
      for (int i = 0; i < PACK; i++) lanes[i] <= '0;
    end else begin
      state <= state_nx;
      inflight <= r_en;
      flush_pend <= flush || (flush_pend && !fill_done);
      if (m_valid && m_ready) begin
        byte_cnt <= '0;
        word_cnt <= word_cnt + 16'd1;
        for (int i = 0; i < PACK; i++) lanes[i] <= '0;
      end else if (inflight) begin
        byte_cnt <= byte_cnt + CW'(1);
        for (int i = 0; i < PACK; i++) if (byte_cnt == CW'(i)) lanes[i] <= fifo_data;
      end
    end
  end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed table and sequence checks of the fifo read packer
module tb_fifo_rd_packer;
  logic rclk, rrst, empty, r_en, flush, m_valid, m_ready;
  logic [7:0] fifo_data;
  logic [31:0] m_data;
  logic [3:0] m_keep;
  logic [15:0] word_cnt;
  logic [7:0] mem [256];
  logic [7:0] wr, rd;
  logic force_empty;
  logic [15:0] exp_wc;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [31:0] din;
    int n;
    logic fl;
    logic [31:0] ed;
    logic [3:0] ek;
  } vec_t;
  vec_t vt [5];
  fifo_rd_packer dut (
    .rclk(rclk), .rrst(rrst), .empty(empty), .fifo_data(fifo_data), .r_en(r_en),
    .flush(flush), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_keep(m_keep), .word_cnt(word_cnt)
  );
  initial rclk = 1'b0;
  always #5 rclk = ~rclk;
  assign empty = force_empty || (wr == rd);
  always @(posedge rclk) begin
    if (r_en && !empty) begin
      fifo_data <= mem[rd];
      rd <= rd + 8'd1;
    end
  end
  task automatic tick();
    @(negedge rclk);
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic push(input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr] = d[i*8 +: 8];
      wr = wr + 8'd1;
    end
  endtask
  task automatic wait_valid(input int max);
    int k = 0;
    while (!m_valid && k < max) begin
      tick();
      k++;
    end
    chk("valid_timeout", {31'd0, m_valid}, 32'd1);
  endtask
  task automatic accept();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    exp_wc = exp_wc + 16'd1;
    chk("word_cnt", {16'd0, word_cnt}, {16'd0, exp_wc});
    chk("valid_after_accept", {31'd0, m_valid}, 32'd0);
  endtask
  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vt[0] = '{32'h44332211, 4, 1'b0, 32'h44332211, 4'b1111};
    vt[1] = '{32'h00003412, 2, 1'b1, 32'h00003412, 4'b0011};
    vt[2] = '{32'h00000001, 1, 1'b1, 32'h00000001, 4'b0001};
    vt[3] = '{32'h00FFA55A, 3, 1'b1, 32'h00FFA55A, 4'b0111};
    vt[4] = '{32'hEFBEADDE, 4, 1'b0, 32'hEFBEADDE, 4'b1111};
    wr = 8'd0;
    rd = 8'd0;
    fifo_data = 8'd0;
    force_empty = 1'b0;
    flush = 1'b0;
    m_ready = 1'b0;
    exp_wc = 16'd0;
    rrst = 1'b1;
    tick();
    tick();
    chk("rst_ren", {31'd0, r_en}, 32'd0);
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_data", m_data, 32'd0);
    chk("rst_keep", {28'd0, m_keep}, 32'd0);
    chk("rst_wcnt", {16'd0, word_cnt}, 32'd0);
    rrst = 1'b0;
    tick();
    push(32'h44332211, 4);
    m_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      #1;
      chk("s1_ren", {31'd0, r_en}, {31'd0, c <= 3});
      chk("s1_valid", {31'd0, m_valid}, {31'd0, c == 5});
      if (c == 5) begin
        chk("s1_data", m_data, 32'h44332211);
        chk("s1_keep", {28'd0, m_keep}, 32'hF);
      end
      if (c == 6) chk("s1_wcnt", {16'd0, word_cnt}, 32'd1);
      tick();
    end
    m_ready = 1'b0;
    exp_wc = 16'd1;
    for (int v = 0; v < 5; v++) begin
      push(vt[v].din, vt[v].n);
      if (vt[v].fl) begin
        repeat (6) tick();
        pulse_flush();
      end
      wait_valid(20);
      chk("tbl_data", m_data, vt[v].ed);
      chk("tbl_keep", {28'd0, m_keep}, {28'd0, vt[v].ek});
      chk("tbl_ren_hold", {31'd0, r_en}, 32'd0);
      accept();
    end
    push(32'h0000BBAA, 2);
    repeat (6) tick();
    pulse_flush();
    push(32'h000000CC, 1);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("s2_ren_blocked", {31'd0, r_en}, 32'd0);
      tick();
    end
    chk("s2_valid", {31'd0, m_valid}, 32'd1);
    chk("s2_data", m_data, 32'h0000BBAA);
    chk("s2_keep", {28'd0, m_keep}, 32'h3);
    accept();
    repeat (4) tick();
    pulse_flush();
    wait_valid(10);
    chk("s2_tail_data", m_data, 32'h000000CC);
    chk("s2_tail_keep", {28'd0, m_keep}, 32'h1);
    accept();
    push(32'h04030201, 4);
    push(32'h08070605, 4);
    wait_valid(20);
    for (int c = 0; c < 10; c++) begin
      chk("s3_stall_data", m_data, 32'h04030201);
      chk("s3_stall_ren", {31'd0, r_en}, 32'd0);
      chk("s3_stall_valid", {31'd0, m_valid}, 32'd1);
      tick();
    end
    accept();
    wait_valid(20);
    chk("s3_second_data", m_data, 32'h08070605);
    chk("s3_second_keep", {28'd0, m_keep}, 32'hF);
    accept();
    push(32'h00002211, 2);
    tick();
    tick();
    force_empty = 1'b1;
    push(32'h00004433, 2);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("s4_gap_ren", {31'd0, r_en}, 32'd0);
      tick();
    end
    force_empty = 1'b0;
    wait_valid(20);
    chk("s4_data", m_data, 32'h44332211);
    chk("s4_keep", {28'd0, m_keep}, 32'hF);
    accept();
    push(32'hA4A3A2A1, 4);
    repeat (3) tick();
    rrst = 1'b1;
    wr = rd;
    tick();
    rrst = 1'b0;
    #1;
    chk("s5_ren", {31'd0, r_en}, 32'd0);
    chk("s5_valid", {31'd0, m_valid}, 32'd0);
    chk("s5_data", m_data, 32'd0);
    chk("s5_keep", {28'd0, m_keep}, 32'd0);
    chk("s5_wcnt", {16'd0, word_cnt}, 32'd0);
    exp_wc = 16'd0;
    tick();
    push(32'hB4B3B2B1, 4);
    wait_valid(20);
    chk("s5_data_after", m_data, 32'hB4B3B2B1);
    chk("s5_keep_after", {28'd0, m_keep}, 32'hF);
    accept();
    pulse_flush();
    for (int c = 0; c < 6; c++) begin
      chk("s6_no_word", {31'd0, m_valid}, 32'd0);
      tick();
    end
    chk("s6_wcnt_same", {16'd0, word_cnt}, {16'd0, exp_wc});
    force dut.word_cnt = 16'hFFFE;
    #1;
    release dut.word_cnt;
    exp_wc = 16'hFFFE;
    chk("s6_preload", {16'd0, word_cnt}, 32'h0000FFFE);
    tick();
    push(32'h13121110, 4);
    wait_valid(20);
    accept();
    push(32'h17161514, 4);
    wait_valid(20);
    chk("s6_data", m_data, 32'h17161514);
    accept();
    chk("s6_wrap", {16'd0, word_cnt}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
